fft_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the FFT datapath ALU. It takes the same operand triple (a, b, c) plus a mode, with generic operand width. New capabilities over the combinational ALU: a 2-stage registered pipeline with valid/ready flow control, a Q-format rounded multiply, and a multiply-accumulate register. It sits between the FFT control FSM (operand/mode issue) and the butterfly writeback path.

---
 rtl/fft_alu_pipe_pkg.sv | 23 ++
 rtl/fft_alu_sat.sv | 24 ++
 rtl/fft_alu_pipe.sv | 130 +++++++++++++
 tb/tb_fft_alu_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_alu_pipe_pkg.sv
// Shared mode encoding and helpers for the pipelined FFT datapath ALU.
// Mode codes keep the legacy combinational-ALU values and add MULT_Q, MAC and ACC_CLR.
package fft_alu_pipe_pkg;

    localparam int MODE_W = 5;

    typedef logic [MODE_W-1:0] alu_mode_t;

    localparam alu_mode_t ALUMODE_IDLE     = 5'd0;
    localparam alu_mode_t ALUMODE_A_ADD_B  = 5'd1;
    localparam alu_mode_t ALUMODE_A_SUB_B  = 5'd2;
    localparam alu_mode_t ALUMODE_A_ADD_C  = 5'd3;
    localparam alu_mode_t ALUMODE_A_MULT_B = 5'd4;
    localparam alu_mode_t ALUMODE_A_MULT_Q = 5'd5;
    localparam alu_mode_t ALUMODE_A_MAC    = 5'd6;
    localparam alu_mode_t ALUMODE_ACC_CLR  = 5'd7;

    // IDLE and ACC_CLR beats are consumed inside the pipe and never reach the output.
    function automatic logic mode_has_output(input alu_mode_t mode);
        return !(mode == ALUMODE_IDLE || mode == ALUMODE_ACC_CLR);
    endfunction

endpackage

// File: rtl/fft_alu_sat.sv
// Combinational signed clamp from IW bits down to the OW-bit signed range.
// Zero latency; no flow control (pure function of din).
module fft_alu_sat #(
    parameter int IW = 33,
    parameter int OW = 32
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        if (din > MAX_V) begin
            dout = MAX_V[OW-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OW-1:0];
        end else begin
            dout = din[OW-1:0];
        end
    end

endmodule

// File: rtl/fft_alu_pipe.sv
// Two-stage pipelined FFT ALU: add/sub/mult, Q-format rounded mult, MAC; FFT_ALU_SAT_EN clamps MULT_Q and MAC.
// Latency 2 cycles accept-to-result, 1 beat/cycle.
// Backpressure: whole pipe freezes while a result is held unaccepted; in_ready_o mirrors the enable.
module fft_alu_pipe
    import fft_alu_pipe_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic signed [W-1:0]   op_a_i,
    input  logic signed [W-1:0]   op_b_i,
    input  logic signed [W-1:0]   op_c_i,
    input  alu_mode_t             alu_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic signed [2*W-1:0] res_o
);

    localparam int RW = 2 * W;
    localparam logic signed [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);

    logic                 en;
    logic signed [RW-1:0] prod_in;

    logic                 s1_vld;
    logic signed [W-1:0]  s1_a;
    logic signed [W-1:0]  s1_b;
    logic signed [W-1:0]  s1_c;
    alu_mode_t            s1_mode;
    logic signed [RW-1:0] s1_prod;

    logic signed [RW-1:0] acc;
    logic signed [RW-1:0] a_x;
    logic signed [RW-1:0] b_x;
    logic signed [RW-1:0] c_x;
    logic signed [RW-1:0] q_rnd;
    logic signed [RW-1:0] q_full;
    logic signed [RW-1:0] q_res;
    logic signed [RW-1:0] mac_sum;
    logic signed [RW-1:0] res_next;
    logic signed [RW-1:0] acc_next;

    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;
    assign prod_in    = RW'(op_a_i) * RW'(op_b_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_c    <= '0;
            s1_mode <= ALUMODE_IDLE;
            s1_prod <= '0;
        end else if (en) begin
            s1_vld  <= in_valid_i;
            s1_a    <= op_a_i;
            s1_b    <= op_b_i;
            s1_c    <= op_c_i;
            s1_mode <= alu_mode_i;
            s1_prod <= prod_in;
        end
    end

    // Operands are widened to 2W first so add/sub can never overflow.
    assign a_x    = RW'(s1_a);
    assign b_x    = RW'(s1_b);
    assign c_x    = RW'(s1_c);
    assign q_rnd  = s1_prod + RND;
    assign q_full = q_rnd >>> FRAC;

`ifdef FFT_ALU_SAT_EN
    logic signed [W-1:0] q_clamp;
    logic signed [RW:0]  mac_wide;

    fft_alu_sat #(.IW(RW), .OW(W)) u_q_sat (
        .din  (q_full),
        .dout (q_clamp)
    );

    assign q_res    = RW'(q_clamp);
    assign mac_wide = (RW+1)'(acc) + (RW+1)'(s1_prod);

    fft_alu_sat #(.IW(RW+1), .OW(RW)) u_mac_sat (
        .din  (mac_wide),
        .dout (mac_sum)
    );
`else
    assign q_res   = q_full;
    assign mac_sum = acc + s1_prod;
`endif

    always_comb begin
        res_next = '0;
        acc_next = acc;
        case (s1_mode)
            ALUMODE_A_ADD_B:  res_next = a_x + b_x;
            ALUMODE_A_SUB_B:  res_next = a_x - b_x;
            ALUMODE_A_ADD_C:  res_next = a_x + c_x;
            ALUMODE_A_MULT_B: res_next = s1_prod;
            ALUMODE_A_MULT_Q: res_next = q_res;
            ALUMODE_A_MAC: begin
                acc_next = mac_sum;
                res_next = mac_sum;
            end
            ALUMODE_ACC_CLR:  acc_next = '0;
            default:          res_next = '0;
        endcase
    end

    // acc lives in stage 2, so consecutive MAC beats see each other's result without forwarding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o <= 1'b0;
            res_o       <= '0;
            acc         <= '0;
        end else if (en) begin
            out_valid_o <= s1_vld && mode_has_output(s1_mode);
            res_o       <= res_next;
            if (s1_vld) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_fft_alu_pipe.sv
// Self-checking bench for fft_alu_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_fft_alu_pipe;

    localparam int W    = 16;
    localparam int FRAC = W - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [W-1:0]   op_a = '0;
    logic signed [W-1:0]   op_b = '0;
    logic signed [W-1:0]   op_c = '0;
    logic [4:0]            alu_mode = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [2*W-1:0] res;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     last_acc_cyc = 0;
    longint m_acc = 0;
    longint exp_q[$];
    longint got_res[$];
    int     got_cyc[$];
    bit     prev_stall = 0;
    longint prev_res = 0;

    fft_alu_pipe #(.W(W), .FRAC(FRAC)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .op_c_i      (op_c),
        .alu_mode_i  (alu_mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic longint wrap2w(input longint v);
        logic signed [2*W-1:0] t;
        t = v[2*W-1:0];
        return longint'(t);
    endfunction

    // Reference behaviour straight from the mode table, in 64-bit arithmetic.
    function automatic void model(input logic [4:0] m, input longint a, input longint b, input longint c,
                                  input longint acc_in, output longint r, output longint acc_out,
                                  output bit has_out);
        longint p;
        longint q;
        longint s;
        p = a * b;
        r = 0;
        acc_out = acc_in;
        has_out = 1;
        case (m)
            5'd0: has_out = 0;
            5'd1: r = a + b;
            5'd2: r = a - b;
            5'd3: r = a + c;
            5'd4: r = p;
            5'd5: begin
                q = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef FFT_ALU_SAT_EN
                if (q > (longint'(1) << (W - 1)) - 1) q = (longint'(1) << (W - 1)) - 1;
                if (q < -(longint'(1) << (W - 1)))    q = -(longint'(1) << (W - 1));
`endif
                r = q;
            end
            5'd6: begin
                s = acc_in + p;
`ifdef FFT_ALU_SAT_EN
                if (s > (longint'(1) << (2*W - 1)) - 1) s = (longint'(1) << (2*W - 1)) - 1;
                if (s < -(longint'(1) << (2*W - 1)))    s = -(longint'(1) << (2*W - 1));
`else
                s = wrap2w(s);
`endif
                acc_out = s;
                r = s;
            end
            5'd7: begin
                acc_out = 0;
                has_out = 0;
            end
            default: r = 0;
        endcase
    endfunction

    // Single compare process: handshake rule, stall stability, output order/value, model update on accept.
    always @(negedge clk) begin
        longint r;
        longint na;
        bit     h;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("stall_valid_hold", longint'(out_valid), 1);
                chk("stall_res_hold", longint'(res), prev_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got beat res=%0d, required no beat", res);
                end else begin
                    chk("stream_res", longint'(res), exp_q.pop_front());
                end
                got_res.push_back(longint'(res));
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                model(alu_mode, longint'(op_a), longint'(op_b), longint'(op_c), m_acc, r, na, h);
                m_acc = na;
                if (h) exp_q.push_back(r);
                last_acc_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = longint'(res);
        end
    end

    task automatic send(input logic [4:0] m, input int a, input int b, input int c, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        in_valid = 1'b1;
        alu_mode = m;
        op_a = a[W-1:0];
        op_b = b[W-1:0];
        op_c = c[W-1:0];
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) waits++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept in 40 cycles, required accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int k = 0; k < 60 && got_res.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_got_count", got_res.size(), n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int     w;
        int     stream_waits;
        logic [31:0] r32;
        longint sat_or_wrap;

        // Reset state
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_res", longint'(res), 0);
        chk("rst_ready", longint'(in_ready), 1);
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Single ADD beat, latency and single-cycle valid
        got_res.delete(); got_cyc.delete();
        send(5'd1, 100, -300, 0, w);
        wait_got(1);
        if (got_res.size() >= 1) begin
            chk("t1_res", got_res[0], -200);
            chk("t1_latency", longint'(got_cyc[0] - last_acc_cyc), 2);
        end
        chk("t1_valid_drop", longint'(out_valid), 0);

        // Streaming: 8 back-to-back beats
        got_res.delete(); got_cyc.delete();
        stream_waits = 0;
        send(5'd4, -32768, 2, 0, w);     stream_waits += w;
        send(5'd2, 1000, -2000, 0, w);   stream_waits += w;
        send(5'd3, -5, 0, 32767, w);     stream_waits += w;
        send(5'd4, 32767, -32768, 0, w); stream_waits += w;
        send(5'd2, -32768, 32767, 0, w); stream_waits += w;
        send(5'd3, 7, 9, -8, w);         stream_waits += w;
        send(5'd4, -3, -7, 0, w);        stream_waits += w;
        send(5'd2, 0, 1, 0, w);          stream_waits += w;
        chk("stream_no_stall", stream_waits, 0);
        wait_got(8);
        if (got_res.size() == 8) begin
            chk("stream_mult0", got_res[0], -65536);
            chk("stream_sub1", got_res[1], 3000);
            chk("stream_addc2", got_res[2], 32762);
            chk("stream_mult3", got_res[3], -1073709056);
            chk("stream_sub4", got_res[4], -65535);
            for (int i = 1; i < 8; i++) chk("stream_contig", longint'(got_cyc[i] - got_cyc[i-1]), 1);
        end

        // Backpressure: two beats pending, sink stalled 5 cycles
        got_res.delete(); got_cyc.delete();
        out_ready = 1'b0;
        send(5'd1, 11, 22, 0, w);
        send(5'd2, 50, 8, 0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready_low", longint'(in_ready), 0);
            chk("bp_valid_high", longint'(out_valid), 1);
            chk("bp_res_head", longint'(res), 33);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_got(2);
        idle(3);
        chk("bp_count", got_res.size(), 2);
        if (got_res.size() == 2) begin
            chk("bp_res0", got_res[0], 33);
            chk("bp_res1", got_res[1], 42);
        end

        // MULT_Q rounding
        got_res.delete(); got_cyc.delete();
        send(5'd5, 16384, 16384, 0, w);
        send(5'd5, -32768, -32768, 0, w);
        send(5'd5, 3, 16384, 0, w);
        send(5'd5, -3, 16384, 0, w);
        wait_got(4);
`ifdef FFT_ALU_SAT_EN
        sat_or_wrap = 32767;
`else
        sat_or_wrap = 32768;
`endif
        if (got_res.size() == 4) begin
            chk("mq_half_sq", got_res[0], 8192);
            chk("mq_neg_one_sq", got_res[1], sat_or_wrap);
            chk("mq_round_up", got_res[2], 2);
            chk("mq_round_neg", got_res[3], -1);
        end

        // MAC sequence and accumulator limit
        got_res.delete(); got_cyc.delete();
        send(5'd7, 0, 0, 0, w);
        send(5'd6, 3, 4, 0, w);
        send(5'd6, -2, 5, 0, w);
        send(5'd6, 100, 100, 0, w);
        send(5'd7, 0, 0, 0, w);
        for (int i = 0; i < 3; i++) send(5'd6, 32767, 32767, 0, w);
        wait_got(6);
        idle(3);
        chk("mac_count", got_res.size(), 6);
`ifdef FFT_ALU_SAT_EN
        sat_or_wrap = 2147483647;
`else
        sat_or_wrap = -1073938429;
`endif
        if (got_res.size() == 6) begin
            chk("mac_12", got_res[0], 12);
            chk("mac_2", got_res[1], 2);
            chk("mac_10002", got_res[2], 10002);
            chk("mac_big1", got_res[3], 1073676289);
            chk("mac_big2", got_res[4], 2147352578);
            chk("mac_big3", got_res[5], sat_or_wrap);
        end

        // IDLE produces nothing, undefined mode gives 0 with valid
        got_res.delete(); got_cyc.delete();
        send(5'd0, 9, 9, 9, w);
        send(5'd20, 1234, 5, 6, w);
        wait_got(1);
        idle(4);
        chk("undef_count", got_res.size(), 1);
        if (got_res.size() == 1) chk("undef_res", got_res[0], 0);

        // Reset with two MAC beats in flight
        send(5'd6, 7, 7, 0, w);
        idle(4);
        send(5'd6, 5, 5, 0, w);
        send(5'd6, 2, 2, 0, w);
        chk("mid_inflight", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_acc = 0;
        #1;
        chk("mid_rst_valid", longint'(out_valid), 0);
        chk("mid_rst_res", longint'(res), 0);
        chk("mid_rst_ready", longint'(in_ready), 1);
        idle(2);
        rst_n = 1'b1;
        got_res.delete(); got_cyc.delete();
        idle(5);
        chk("mid_no_stale", got_res.size(), 0);
        send(5'd6, 1, 1, 0, w);
        wait_got(1);
        if (got_res.size() == 1) chk("mid_acc_cleared", got_res[0], 1);

        // Randomized traffic with random sink backpressure
        for (int i = 0; i < 600; i++) begin
            bit hold;
            @(negedge clk);
            hold = in_valid && !in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 4) != 0);
                r32 = $urandom_range(0, 9);
                alu_mode = (r32 >= 8) ? 5'($urandom_range(8, 31)) : r32[4:0];
                r32 = $urandom; op_a = r32[W-1:0];
                r32 = $urandom; op_b = r32[W-1:0];
                r32 = $urandom; op_c = r32[W-1:0];
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
